instr_encoder_loader: RTL

Sequential instruction encoder and program-memory writer. It is the write-side counterpart of the decode stage.
- Accepts opcode and operand fields over a valid/ready handshake.
- Packs them into the 32-bit instruction word format that decode consumes.
- Writes the word to consecutive instruction-memory addresses.
- Used by the boot/test loader to fill the Harvard instruction memory before the core runs.

---
 rtl/instr_encoder_loader_if.sv | 22 ++
 rtl/instr_encoder_loader.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader_if.sv
// Field-bundle handshake between a loader front end and the instruction encoder.
interface instr_encoder_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [4:0]  rdst2;
    logic [4:0]  rdst1;
    logic [4:0]  rsrc2;
    logic [4:0]  rsrc1;
    logic [15:0] imm16;
    logic [7:0]  addr8;

    modport master (
        output in_valid, opcode, rdst2, rdst1, rsrc2, rsrc1, imm16, addr8,
        input  in_ready
    );

    modport slave (
        input  in_valid, opcode, rdst2, rdst1, rsrc2, rsrc1, imm16, addr8,
        output in_ready
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs opcode/operand bundles into 32-bit instruction words and writes them to
// consecutive instruction-memory addresses. Optional ENC_CHECKSUM_EN adds a running XOR.
module instr_encoder_loader #(
    parameter int AW    = 8,
    parameter int DEPTH = 256,
    parameter int BASE  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  finish,
    instr_encoder_loader_if.slave bus,
    output logic                  imem_we,
    output logic [AW-1:0]         imem_addr,
    output logic [31:0]           imem_wdata,
    output logic [AW:0]           count,
    output logic                  full,
    output logic                  err,
    output logic                  done
`ifdef ENC_CHECKSUM_EN
    ,
    output logic [31:0]           checksum
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL} state_t;

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] BASE_C  = AW'(BASE);

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [AW:0]   count_q, count_d;
    logic          we_q, we_d;
    logic          full_q, full_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic [31:0]   csum_q, csum_d;

    logic [31:0]   word;
    logic          legal;
    logic          ready;
    logic          accept;
    logic [AW:0]   count_inc;

    // Encoder: every bit not named by the opcode's format stays zero.
    always_comb begin
        word  = '0;
        legal = 1'b1;
        word[31:26] = bus.opcode;
        if (bus.opcode == 6'd0) begin
            word[25:21] = bus.rdst2;
            word[15:0]  = bus.imm16;
        end else if (bus.opcode == 6'd1) begin
            word[25:21] = bus.rdst2;
            word[4:0]   = bus.rsrc2;
        end else if (bus.opcode == 6'd2) begin
            word[25:21] = bus.rdst2;
            word[7:0]   = bus.addr8;
        end else if (bus.opcode == 6'd3) begin
            word[25:18] = bus.addr8;
            word[4:0]   = bus.rsrc2;
        end else if (bus.opcode <= 6'd16) begin
            word[25:21] = bus.rdst2;
            word[20:16] = bus.rdst1;
            word[9:5]   = bus.rsrc2;
            word[4:0]   = bus.rsrc1;
        end else begin
            word  = '0;
            legal = 1'b0;
        end
    end

    always_comb begin
        ready     = (state_q == S_LOAD) && !full_q;
        accept    = bus.in_valid && ready;
        count_inc = count_q + (AW+1)'(1);

        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        we_d    = 1'b0;
        full_d  = full_q;
        err_d   = err_q;
        done_d  = done_q;
        csum_d  = csum_q;

        if (start) begin
            // A bundle handshaking alongside start is dropped on purpose.
            state_d = S_LOAD;
            ptr_d   = BASE_C;
            addr_d  = BASE_C;
            count_d = '0;
            full_d  = 1'b0;
            err_d   = 1'b0;
            done_d  = 1'b0;
            csum_d  = '0;
        end else begin
            if (we_q) begin
                addr_d = ptr_q;
            end
            if (accept && legal) begin
                we_d    = 1'b1;
                wdata_d = word;
                addr_d  = ptr_q;
                count_d = count_inc;
                csum_d  = csum_q ^ word;
                // Hold the pointer on the last slot so the address never wraps.
                if (count_inc < DEPTH_C) begin
                    ptr_d = ptr_q + AW'(1);
                end else begin
                    full_d  = 1'b1;
                    state_d = S_FULL;
                end
            end else if (accept) begin
                err_d = 1'b1;
            end
            if (finish && (state_q != S_IDLE)) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= BASE_C;
            addr_q  <= BASE_C;
            wdata_q <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            we_q    <= we_d;
            full_q  <= full_d;
            err_q   <= err_d;
            done_q  <= done_d;
            csum_q  <= csum_d;
        end
    end

    assign bus.in_ready = ready;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign count        = count_q;
    assign full         = full_q;
    assign err          = err_q;
    assign done         = done_q;
`ifdef ENC_CHECKSUM_EN
    assign checksum     = csum_q;
`else
    logic unused_csum;
    assign unused_csum = ^csum_q;
`endif

endmodule
